// File: rtl/fas_pkg.sv
// Shared types and sizing for the FIR-to-FFT frame scheduler.
// Sample width, frame size, address width, counter width and FSM states.
package fas_pkg;
  localparam int DW = 16;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_e;

  typedef logic signed [DW-1:0] sample_t;
endpackage

// File: rtl/frame_bank.sv
// Two-bank ping-pong sample store: one synchronous write port and one
// combinational read port. Cleared on reset so the read port never shows X.
module frame_bank
  import fas_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  sample_t       wr_data_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output sample_t       rd_data_o
);
  sample_t mem_q [2][N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < N; a++) begin
          mem_q[b][a] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];
endmodule

// File: rtl/fft_frame_scheduler.sv
// Packs the FIR sample stream into 16-sample frames across two banks,
// launches the FFT engine on each full frame and releases banks on completion.
module fft_frame_scheduler
  import fas_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          fir_valid,
  input  logic [DW-1:0] fir_d,
  input  logic          fft_ready,
  input  logic          fft_done,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          fft_start,
  output logic          fft_bank,
  output logic          busy,
  output logic [CW-1:0] frame_cnt,
  output logic          overrun
);
  state_e        state_q, state_d;
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          rd_bank_q, rd_bank_d;
  logic          fft_bank_q, fft_bank_d;
  logic          start_q, start_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          accept;
  sample_t       bank_rd;

  // The full flag is sampled before this cycle's release, so a write into a
  // bank being freed on the same edge is still dropped.
  assign accept = fir_valid && !full_q[wr_bank_q];

  frame_bank u_bank (
    .clk       (clk),
    .rst       (rst),
    .we_i      (accept),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (sample_t'(fir_d)),
    .rd_bank_i (fft_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (bank_rd)
  );

  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    rd_bank_d  = rd_bank_q;
    fft_bank_d = fft_bank_q;
    start_d    = 1'b0;
    cnt_d      = cnt_q;
    ovr_d      = ovr_q;

    if (fir_valid && full_q[wr_bank_q]) begin
      ovr_d = 1'b1;
    end

    if (accept) begin
      if (wr_ptr_q == AW'(N-1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_ptr_d          = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // Fill and release never touch the same bank: fill needs it empty,
    // release needs it full.
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q] && fft_ready) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start_d    = 1'b1;
        fft_bank_d = rd_bank_q;
        state_d    = RUN;
      end
      RUN: begin
        if (fft_done) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          cnt_d             = cnt_q + 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_bank_q  <= 1'b0;
      fft_bank_q <= 1'b0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_bank_q  <= rd_bank_d;
      fft_bank_q <= fft_bank_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rd_data   = bank_rd;
  assign fft_start = start_q;
  assign fft_bank  = fft_bank_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = cnt_q;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: a frame-queue reference model
// plus a bench-side FFT engine that reads each launched frame back.
module tb_fft_frame_scheduler;
  import fas_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          fir_valid;
  logic [DW-1:0] fir_d;
  logic          fft_ready;
  logic          fft_done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          fft_start;
  logic          fft_bank;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic          overrun;

  always #20 clk = ~clk;

  fft_frame_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .fir_valid (fir_valid),
    .fir_d     (fir_d),
    .fft_ready (fft_ready),
    .fft_done  (fft_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .fft_start (fft_start),
    .fft_bank  (fft_bank),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .overrun   (overrun)
  );

  // ---------------- checker ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frames complete in fill order; a bank is held from fill until the engine
  // reports done. Two held frames means the next sample has nowhere to go.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_q[$];
  logic [DW-1:0] run_frame [N];
  int            m_pending;
  logic          m_idle, m_running, m_launch_due, m_overrun, m_rd_bank;
  logic [CW-1:0] m_frames;
  int            total_done;
  int            run_age;
  int            done_delay;
  logic          hold_done, force_done, rand_delay;

  task automatic model_reset();
    exp_q.delete();
    cur_q.delete();
    m_pending    = 0;
    m_idle       = 1'b1;
    m_running    = 1'b0;
    m_launch_due = 1'b0;
    m_overrun    = 1'b0;
    m_rd_bank    = 1'b0;
    m_frames     = '0;
    total_done   = 0;
    run_age      = 0;
  endtask

  // ---------------- driver: one clock cycle, starting at a negedge ----------------
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy);
    logic exp_start, launch, drop, fill;
    fir_valid = v;
    fir_d     = d;
    fft_ready = rdy;
    fft_done  = (m_running && !hold_done && (run_age + 1 >= done_delay)) || force_done;
    force_done = 1'b0;

    exp_start    = m_launch_due;
    m_launch_due = 1'b0;
    launch       = m_idle && (m_pending > 0) && rdy;
    drop         = v && (m_pending == 2);
    fill         = 1'b0;
    if (v) begin
      if (drop) begin
        m_overrun = 1'b1;
      end else begin
        cur_q.push_back(d);
        if (cur_q.size() == N) begin
          foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
          cur_q.delete();
          fill = 1'b1;
        end
      end
    end
    if (fft_done && m_running) begin
      m_pending--;
      m_frames++;
      total_done++;
      m_rd_bank ^= 1'b1;
      m_running = 1'b0;
      m_idle    = 1'b1;
    end
    if (fill) m_pending++;
    if (launch) begin
      m_idle       = 1'b0;
      m_launch_due = 1'b1;
    end

    @(posedge clk);
    #1;
    if (m_running) run_age++;
    check("fft_start", fft_start, exp_start);
    check("busy", busy, !m_idle);
    check("frame_cnt", frame_cnt, m_frames);
    check("overrun", overrun, m_overrun);
    if (exp_start) begin
      check("fft_bank", fft_bank, m_rd_bank);
      check("frame_queued", exp_q.size() >= N, 1);
      for (int i = 0; i < N; i++) run_frame[i] = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      m_running = 1'b1;
      run_age   = 0;
      if (rand_delay) done_delay = $urandom_range(1, 12);
      for (int i = 0; i < N; i++) begin
        rd_addr = AW'(i);
        #1;
        check("rd_data", rd_data, run_frame[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #5;
    rst = 1'b1;
    #1;
    check("rst_fft_start", fft_start, 0);
    check("rst_fft_bank", fft_bank, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rd_data", rd_data, 0);
    model_reset();
    fir_valid = 1'b0;
    fft_done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  initial begin
    rst = 1'b1; fir_valid = 1'b0; fir_d = '0; fft_ready = 1'b0; fft_done = 1'b0; rd_addr = '0;
    hold_done = 1'b0; force_done = 1'b0; rand_delay = 1'b0; done_delay = 5;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: single frame of 1..16, launch two edges after the 16th sample
    for (int i = 1; i <= N; i++) cycle(1'b1, DW'(i), 1'b1);
    idle_cycles(12, 1'b1);
    check("t1_frames", frame_cnt, 1);

    // 2: two back-to-back frames, done 5 cycles after each start
    do_reset();
    done_delay = 5;
    for (int i = 0; i < 2 * N; i++) cycle(1'b1, DW'($urandom), 1'b1);
    idle_cycles(30, 1'b1);
    check("t2_frames", frame_cnt, 2);
    check("t2_overrun", overrun, 0);

    // 3: engine never finishes; the 33rd sample is dropped
    do_reset();
    hold_done = 1'b1;
    for (int i = 0; i < 2 * N + 1; i++) cycle(1'b1, DW'($urandom), 1'b1);
    idle_cycles(5, 1'b1);
    check("t3_overrun", overrun, 1);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      #1;
      check("t3_bank0_kept", rd_data, run_frame[i]);
    end
    hold_done = 1'b0;

    // 4: done while idle is ignored; frame waits while fft_ready is low
    do_reset();
    force_done = 1'b1;
    idle_cycles(2, 1'b1);
    check("t4_done_ignored", frame_cnt, 0);
    for (int i = 0; i < N; i++) cycle(1'b1, DW'($urandom), 1'b0);
    idle_cycles(20, 1'b0);
    check("t4_held", busy, 0);
    idle_cycles(15, 1'b1);
    check("t4_frames", frame_cnt, 1);

    // 5: reset mid-run with bank 1 half filled, then a fresh frame uses bank 0
    do_reset();
    hold_done = 1'b1;
    for (int i = 0; i < N + N / 2; i++) cycle(1'b1, DW'($urandom), 1'b1);
    hold_done = 1'b0;
    do_reset();
    for (int i = 0; i < N; i++) cycle(1'b1, DW'($urandom), 1'b1);
    idle_cycles(12, 1'b1);
    check("t5_frames", frame_cnt, 1);

    // 6: bank 1 fills on the same edge that bank 0 is released
    do_reset();
    done_delay = 14;
    for (int i = 0; i < 2 * N; i++) cycle(1'b1, DW'($urandom), 1'b1);
    idle_cycles(25, 1'b1);
    check("t6_overrun", overrun, 0);
    check("t6_frames", frame_cnt, 2);

    // 7: 256 randomized frames wrap the counter
    do_reset();
    rand_delay = 1'b1;
    done_delay = 3;
    begin
      int cyc;
      cyc = 0;
      while (total_done < 256 && cyc < 30000) begin
        cycle(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 4) != 0));
        cyc++;
      end
      check("t7_budget", (cyc < 30000), 1);
    end
    check("t7_wrap", frame_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
